// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with fixed wait states, byte-enable writes,
// out-of-range error responses and a sticky halt flag raised by a write to HALT_ADDR.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2,
    parameter int HALT_ADDR   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  halt
);
    // state  | meaning
    // S_IDLE | ready for a request
    // S_WAIT | request captured, counting wait states
    // S_RESP | response presented, waiting for rsp_ready
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] HALT_A  = ADDR_W'(HALT_ADDR);
    localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [BE_W-1:0]     cap_be;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                commit;
    logic                c_we;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_wdata;
    logic [BE_W-1:0]     c_be;
    logic                c_in_range;
    logic                c_halt_wr;
    logic [IDX_W-1:0]    c_idx;

    assign accept = (state == S_IDLE) && req_ready && req_valid;
    assign commit = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd1));

    // With no wait states the commit happens on the accepting edge, so use the live request.
    assign c_we       = (state == S_IDLE) ? req_we    : cap_we;
    assign c_addr     = (state == S_IDLE) ? req_addr  : cap_addr;
    assign c_wdata    = (state == S_IDLE) ? req_wdata : cap_wdata;
    assign c_be       = (state == S_IDLE) ? req_be    : cap_be;
    assign c_in_range = c_addr < DEPTH_A;
    assign c_halt_wr  = c_we && (c_addr == HALT_A);
    assign c_idx      = c_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            halt      <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else begin
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= !c_in_range && !c_halt_wr;
                rsp_rdata <= (!c_we && c_in_range) ? mem[c_idx] : '0;
                if (c_halt_wr && (c_wdata != '0))
                    halt <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_LD;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; writes land only on the commit edge.
    always_ff @(posedge clk) begin
        if (commit && c_we && c_in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (c_be[b])
                    mem[c_idx][b*8 +: 8] <= c_wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Drives one request stream into two responders (WAIT_CYCLES=2 and 0) and checks
// each against its own word-level memory model.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b1;
    logic        rdy [2];
    logic        rv  [2];
    logic        err [2];
    logic        hlt [2];
    logic [31:0] rd  [2];

    int errors = 0;
    int checks = 0;
    int wc [2] = '{2, 0};

    logic [31:0] mm [2][128];
    bit          kn [2][128];
    bit          hm [2];

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(err[0]),
        .halt(hlt[0]));

    data_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(err[1]),
        .halt(hlt[1]));

    task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, output time acc_t);
        logic [31:0] erd [2];
        logic        eerr [2];
        bit          echk [2];
        logic [31:0] srd [2];
        logic        serr [2];
        bit          got [2];
        bit          done [2];
        int          n;
        int          t;
        bit          inr;
        bit          hw;
        t = 0;
        @(negedge clk);
        while (!(rdy[0] && rdy[1]) && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!(rdy[0] && rdy[1])) begin
            errors++;
            $display("FAIL ready_wait: req_ready=%b/%b, required 1/1", rdy[0], rdy[1]);
        end
        inr = addr < 8'd128;
        hw  = we && (addr == 8'd255);
        for (int k = 0; k < 2; k++) begin
            eerr[k] = !inr && !hw;
            echk[k] = we || !inr || kn[k][addr[6:0]];
            erd[k]  = (we || !inr) ? 32'h0 : mm[k][addr[6:0]];
            if (we && inr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mm[k][addr[6:0]][b*8 +: 8] = wdata[b*8 +: 8];
                if (be == 4'hF) kn[k][addr[6:0]] = 1'b1;
            end
            if (hw && wdata != 32'h0) hm[k] = 1'b1;
            got[k]  = 1'b0;
            done[k] = 1'b0;
            srd[k]  = '0;
            serr[k] = 1'b0;
        end
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk);
        acc_t = $time;
        #1;
        req_valid = 1'b0;
        n = 1;
        forever begin
            for (int k = 0; k < 2; k++) begin
                if (got[k] && !done[k] && rsp_ready) begin
                    checks++;
                    if (rv[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL rsp_complete[%0d]: rsp_valid=%b after rsp_ready edge, required 0", k, rv[k]);
                    end
                    done[k] = 1'b1;
                end else if (!got[k] && rv[k] === 1'b1) begin
                    got[k] = 1'b1;
                    srd[k] = rd[k];
                    serr[k] = err[k];
                    checks += 3;
                    if (n != wc[k] + 1) begin
                        errors++;
                        $display("FAIL rsp_timing[%0d]: rsp_valid after %0d edges, required %0d", k, n, wc[k] + 1);
                    end
                    if (err[k] !== eerr[k]) begin
                        errors++;
                        $display("FAIL rsp_err[%0d] addr=%0d: got %b, required %b", k, addr, err[k], eerr[k]);
                    end
                    if (hlt[k] !== hm[k]) begin
                        errors++;
                        $display("FAIL halt[%0d] addr=%0d: got %b, required %b", k, addr, hlt[k], hm[k]);
                    end
                    if (echk[k]) begin
                        checks++;
                        if (rd[k] !== erd[k]) begin
                            errors++;
                            $display("FAIL rsp_rdata[%0d] addr=%0d: got %h, required %h", k, addr, rd[k], erd[k]);
                        end
                    end
                end
            end
            if (!rsp_ready && got[0] && got[1]) begin
                repeat (hold) begin
                    @(posedge clk); #1; n++;
                    for (int k = 0; k < 2; k++) begin
                        checks++;
                        if (rv[k] !== 1'b1 || rd[k] !== srd[k] || err[k] !== serr[k] || rdy[k] !== 1'b0) begin
                            errors++;
                            $display("FAIL hold_stable[%0d]: valid=%b data=%h err=%b ready=%b, required 1 %h %b 0",
                                     k, rv[k], rd[k], err[k], rdy[k], srd[k], serr[k]);
                        end
                    end
                end
                @(negedge clk);
                rsp_ready = 1'b1;
            end
            if ((done[0] && done[1]) || n >= 40) break;
            @(posedge clk); #1; n++;
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (!(got[k] && done[k])) begin
                errors++;
                $display("FAIL rsp_timeout[%0d]: got=%b done=%b, required 1 1", k, got[k], done[k]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv[k] !== 1'b0 || rdy[k] !== 1'b0 || err[k] !== 1'b0 || rd[k] !== 32'h0 || hlt[k] !== 1'b0) begin
                errors++;
                $display("FAIL %s[%0d]: valid=%b ready=%b err=%b rdata=%h halt=%b, required all 0",
                         tag, k, rv[k], rdy[k], err[k], rd[k], hlt[k]);
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rdy[k] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset[%0d]: got %b, required 1", k, rdy[k]);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_state");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_held");
        release_reset();
    endtask

    task automatic test_basic();
        time t;
        access(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 0, t);
        access(1'b0, 8'd5, 32'h0, 4'h0, 0, t);
    endtask

    task automatic test_byte_enable();
        time t;
        access(1'b1, 8'd7, 32'h11223344, 4'hF, 0, t);
        access(1'b1, 8'd7, 32'hAABBCCDD, 4'h5, 0, t);
        access(1'b0, 8'd7, 32'h0, 4'h0, 0, t);
        checks++;
        if (rd[0] !== 32'h0 && mm[0][7] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_model: model %h, required 11BB33DD", mm[0][7]);
        end
        access(1'b1, 8'd7, 32'hFFFFFFFF, 4'h0, 0, t);
        access(1'b0, 8'd7, 32'h0, 4'h0, 0, t);
    endtask

    task automatic test_out_of_range();
        time t;
        access(1'b0, 8'd200, 32'h0, 4'h0, 0, t);
        access(1'b0, 8'd5, 32'h0, 4'h0, 0, t);
        access(1'b1, 8'd72, 32'h01020304, 4'hF, 0, t);
        access(1'b1, 8'd200, 32'hCAFEF00D, 4'hF, 0, t);
        access(1'b0, 8'd72, 32'h0, 4'h0, 0, t);
        access(1'b1, 8'd127, 32'h7F7F7F7F, 4'hF, 0, t);
        access(1'b1, 8'd128, 32'h80808080, 4'hF, 0, t);
        access(1'b0, 8'd127, 32'h0, 4'h0, 0, t);
        access(1'b0, 8'd128, 32'h0, 4'h0, 0, t);
        access(1'b0, 8'd255, 32'h0, 4'h0, 0, t);
    endtask

    task automatic test_hold();
        time t;
        access(1'b0, 8'd5, 32'h0, 4'h0, 4, t);
        access(1'b1, 8'd6, 32'h55AA55AA, 4'hF, 4, t);
    endtask

    task automatic test_random();
        time t;
        for (int i = 0; i < 32; i++)
            access(1'b1, 8'(i), $urandom, 4'hF, 0, t);
        for (int i = 0; i < 60; i++) begin
            logic       we;
            logic [7:0] a;
            int         h;
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 254)) : 8'($urandom_range(0, 31));
            h  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            access(we, a, $urandom, 4'($urandom), h, t);
        end
    endtask

    task automatic test_back_to_back();
        time t0, t1, t2;
        access(1'b1, 8'd40, 32'h0BADCAFE, 4'hF, 0, t0);
        access(1'b0, 8'd40, 32'h0, 4'h0, 0, t1);
        access(1'b0, 8'd5, 32'h0, 4'h0, 0, t2);
        checks += 2;
        if (t1 - t0 != 40) begin
            errors++;
            $display("FAIL throughput_a: accept spacing %0t, required 40", t1 - t0);
        end
        if (t2 - t1 != 40) begin
            errors++;
            $display("FAIL throughput_b: accept spacing %0t, required 40", t2 - t1);
        end
    endtask

    task automatic test_halt();
        time t;
        access(1'b1, 8'd255, 32'h0, 4'hF, 0, t);
        access(1'b1, 8'd255, 32'h1, 4'hF, 0, t);
        access(1'b0, 8'd5, 32'h0, 4'h0, 0, t);
        access(1'b1, 8'd10, 32'h10101010, 4'hF, 0, t);
        access(1'b0, 8'd10, 32'h0, 4'h0, 0, t);
    endtask

    task automatic test_reset_mid_wait();
        time t;
        access(1'b1, 8'd9, 32'h0, 4'hF, 0, t);
        @(negedge clk);
        req_we = 1'b1; req_addr = 8'd9; req_wdata = 32'h12345678; req_be = 4'hF;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        mm[1][9] = 32'h12345678;
        checks++;
        if (rv[0] !== 1'b0 || rv[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: got %b/%b, required 0/1", rv[0], rv[1]);
        end
        #2 rst_n = 1'b0;
        hm[0] = 1'b0;
        hm[1] = 1'b0;
        #1 check_reset_outputs("reset_mid_wait");
        rsp_ready = 1'b1;
        release_reset();
        access(1'b0, 8'd9, 32'h0, 4'h0, 0, t);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_out_of_range();
        test_hold();
        test_random();
        test_back_to_back();
        test_halt();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end
endmodule
